// File: rtl/i2c_burst_master.sv
// rtl/i2c_burst_master.sv - Parametrised byte-burst I2C master (START, addr+R/W, 0..MAX_BYTES data, STOP)
//
// Purpose: issues one I2C transaction per accepted start: START, {addr,rw}, a write or read stream of
// up to MAX_BYTES bytes, then STOP. Address/data NACKs from the slave are reported on nack_o.
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   start_i                 begin transaction (sampled only while idle)
//   addr_i, rw_i            7-bit slave address and direction (1 = read), latched at start
//   num_bytes_i             data byte count, latched at start, clamped to MAX_BYTES
//   wr_data_i / wr_ready_o  write byte and its one-cycle "sampled" pulse
//   rd_data_o / rd_valid_o  last received byte and its one-cycle update pulse
//   busy_o, done_o, nack_o  transaction status; nack_o is valid with done_o and held until next start
//   i2c_scl_o               SCL, push-pull
//   i2c_sda_out_o           SDA drive value (always 0, open-drain)
//   i2c_sda_in_i            SDA pin readback
//   i2c_sda_dir_o           1 = pull SDA low, 0 = release
module i2c_burst_master #(
    parameter int CLK_DIV   = 50,
    parameter int MAX_BYTES = 16,
    localparam int CW = $clog2(MAX_BYTES + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [6:0]    addr_i,
    input  logic          rw_i,
    input  logic [CW-1:0] num_bytes_i,
    input  logic [7:0]    wr_data_i,
    output logic          wr_ready_o,
    output logic [7:0]    rd_data_o,
    output logic          rd_valid_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          nack_o,
    output logic          i2c_scl_o,
    output logic          i2c_sda_out_o,
    input  logic          i2c_sda_in_i,
    output logic          i2c_sda_dir_o
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, STOP
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    qtr_q, qtr_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rw_q, rw_d;
    logic          ack_q, ack_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          nack_q, nack_d;
    logic          wr_ready_q, wr_ready_d;
    logic          rd_valid_q, rd_valid_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          sda_meta_q, sda_sync_q;
    logic          tick, phase_end, sample;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            div_q      <= '0;
            qtr_q      <= '0;
            bit_q      <= '0;
            sh_q       <= '0;
            cnt_q      <= '0;
            rw_q       <= 1'b0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            nack_q     <= 1'b0;
            wr_ready_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            qtr_q      <= qtr_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            rw_q       <= rw_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            nack_q     <= nack_d;
            wr_ready_q <= wr_ready_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            sda_meta_q <= i2c_sda_in_i;
            sda_sync_q <= sda_meta_q;
        end
    end

    assign tick      = busy_q && (div_q == DW'(CLK_DIV - 1));
    assign phase_end = tick && (qtr_q == 2'd3);
    // SDA is read at the end of q2, while SCL is high and the slave's data is settled.
    assign sample    = tick && (qtr_q == 2'd2);

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        qtr_d      = qtr_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        rw_d       = rw_q;
        ack_d      = ack_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        nack_d     = nack_q;
        wr_ready_d = 1'b0;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;

        if (busy_q) div_d = tick ? '0 : div_q + 1'b1;
        if (tick)   qtr_d = qtr_q + 2'd1;

        case (state_q)
            IDLE: if (start_i) begin
                state_d = START;
                busy_d  = 1'b1;
                nack_d  = 1'b0;
                sh_d    = {addr_i, rw_i};
                rw_d    = rw_i;
                cnt_d   = (num_bytes_i > CW'(MAX_BYTES)) ? CW'(MAX_BYTES) : num_bytes_i;
                div_d   = '0;
                qtr_d   = '0;
                bit_d   = '0;
            end
            START: if (phase_end) state_d = ADDR;
            ADDR, WRITE: if (phase_end) begin
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = (state_q == ADDR) ? ADDR_ACK : WRITE_ACK;
                else               sh_d    = {sh_q[6:0], 1'b0};
            end
            ADDR_ACK, WRITE_ACK: begin
                if (sample) ack_d = sda_sync_q;
                if (phase_end) begin
                    if (state_q == WRITE_ACK) cnt_d = cnt_q - CW'(1);
                    if (ack_q) begin
                        nack_d  = 1'b1;
                        state_d = STOP;
                    end else if ((state_q == ADDR_ACK && cnt_q == '0) ||
                                 (state_q == WRITE_ACK && cnt_q == CW'(1))) begin
                        state_d = STOP;
                    end else if (rw_q) begin
                        state_d = READ;
                    end else begin
                        state_d    = WRITE;
                        sh_d       = wr_data_i;
                        wr_ready_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (sample) sh_d = {sh_q[6:0], sda_sync_q};
                if (phase_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d    = READ_ACK;
                        rd_data_d  = sh_q;
                        rd_valid_d = 1'b1;
                    end
                end
            end
            READ_ACK: if (phase_end) begin
                cnt_d   = cnt_q - CW'(1);
                state_d = (cnt_q == CW'(1)) ? STOP : READ;
            end
            STOP: if (phase_end) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus pins decoded from the registered phase; q0/q1 hold SCL low, q2/q3 high.
    always_comb begin
        i2c_scl_o     = 1'b1;
        i2c_sda_dir_o = 1'b0;
        case (state_q)
            START: i2c_sda_dir_o = qtr_q[1];
            ADDR, WRITE: begin
                i2c_scl_o     = qtr_q[1];
                i2c_sda_dir_o = ~sh_q[7];
            end
            ADDR_ACK, WRITE_ACK, READ: i2c_scl_o = qtr_q[1];
            READ_ACK: begin
                i2c_scl_o     = qtr_q[1];
                i2c_sda_dir_o = (cnt_q != CW'(1));   // NACK the final byte
            end
            STOP: begin
                i2c_scl_o     = qtr_q[1];
                i2c_sda_dir_o = (qtr_q != 2'd3);
            end
            default: ;
        endcase
    end

    assign i2c_sda_out_o = 1'b0;
    assign wr_ready_o    = wr_ready_q;
    assign rd_valid_o    = rd_valid_q;
    assign rd_data_o     = rd_data_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign nack_o        = nack_q;

endmodule

// File: tb/tb_i2c_burst_master.sv
// tb/tb_i2c_burst_master.sv - Self-checking bench for i2c_burst_master with an I2C slave and bus monitor
module tb_i2c_burst_master;
    localparam int CD = 2;
    localparam int MB = 16;
    localparam int CW = $clog2(MB + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [6:0]    addr = '0;
    logic          rw = 1'b0;
    logic [CW-1:0] num_bytes = '0;
    logic [7:0]    wr_data = '0;
    logic          wr_ready, rd_valid, busy, done, nack, scl, sda_out, sda_dir;
    logic [7:0]    rd_data;
    logic          slave_low = 1'b0;
    logic          sda_bus;

    assign sda_bus = ~(sda_dir | slave_low);

    always #5 clk = ~clk;

    i2c_burst_master #(.CLK_DIV(CD), .MAX_BYTES(MB)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .addr_i(addr), .rw_i(rw),
        .num_bytes_i(num_bytes), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
        .rd_data_o(rd_data), .rd_valid_o(rd_valid), .busy_o(busy), .done_o(done),
        .nack_o(nack), .i2c_scl_o(scl), .i2c_sda_out_o(sda_out),
        .i2c_sda_in_i(sda_bus), .i2c_sda_dir_o(sda_dir)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave configuration and transaction log
    logic       slave_en = 1'b1;
    logic [7:0] rd_src[$];
    logic [7:0] wr_src[$];
    logic [7:0] bus_bytes[$];
    logic       bus_acks[$];
    logic [7:0] rd_seen[$];
    int n_start, n_stop, n_done, n_overlap, n_wr_ready, wr_idx, busy_cycles;

    logic       prev_scl = 1'b1, prev_sda = 1'b1, mon_sda, in_xfer = 1'b0, is_read = 1'b0;
    logic [7:0] cur = '0, mon_b;
    int         bitpos = 0, byte_idx = 0;

    // Bus monitor + slave: decodes the bus as seen between clock edges and answers on SCL falls.
    always @(negedge clk) begin
        mon_sda = sda_bus;
        if (!rst_n) begin
            slave_low = 1'b0;
            in_xfer   = 1'b0;
        end else begin
            if (wr_ready) begin
                n_wr_ready++;
                wr_idx++;
                if (wr_idx < wr_src.size()) wr_data = wr_src[wr_idx];
            end
            if (rd_valid) rd_seen.push_back(rd_data);
            if (busy) busy_cycles++;
            if (done) begin
                n_done++;
                if (busy) n_overlap++;
            end
            if (prev_scl && scl && prev_sda && !mon_sda) begin
                n_start++;
                in_xfer = 1'b1; bitpos = 0; byte_idx = 0; is_read = 1'b0; slave_low = 1'b0;
            end else if (prev_scl && scl && !prev_sda && mon_sda) begin
                n_stop++;
                in_xfer = 1'b0; slave_low = 1'b0;
            end else if (in_xfer && !prev_scl && scl) begin
                if (bitpos < 8) cur = {cur[6:0], mon_sda};
                if (bitpos == 7) begin
                    bus_bytes.push_back(cur);
                    if (byte_idx == 0) is_read = cur[0];
                end
                if (bitpos == 8) bus_acks.push_back(mon_sda);
                bitpos++;
                if (bitpos == 9) begin
                    bitpos = 0;
                    byte_idx++;
                end
            end else if (in_xfer && prev_scl && !scl) begin
                if (bitpos == 8) begin
                    slave_low = slave_en && (byte_idx == 0 || !is_read);
                end else if (slave_en && is_read && byte_idx >= 1 && byte_idx <= rd_src.size()) begin
                    mon_b     = rd_src[byte_idx-1];
                    slave_low = ~mon_b[7-bitpos];
                end else begin
                    slave_low = 1'b0;
                end
            end
        end
        prev_scl = scl;
        prev_sda = mon_sda;
    end

    task automatic clear_logs();
        bus_bytes.delete(); bus_acks.delete(); rd_seen.delete();
        n_start = 0; n_stop = 0; n_done = 0; n_overlap = 0;
        n_wr_ready = 0; wr_idx = 0; busy_cycles = 0;
    endtask

    // Runs one transaction and checks it against the expected I2C frame.
    task automatic run_txn(input logic [6:0] a, input logic r, input int nb, input logic present,
                           input logic poke);
        int ne, nx, to;
        ne = (nb > MB) ? MB : nb;
        nx = present ? ne : 0;
        while (wr_src.size() < ne) wr_src.push_back(8'($urandom_range(0, 255)));
        while (rd_src.size() < ne) rd_src.push_back(8'($urandom_range(0, 255)));
        clear_logs();
        slave_en = present;
        wr_data  = (wr_src.size() > 0) ? wr_src[0] : 8'h00;
        @(negedge clk);
        addr = a; rw = r; num_bytes = CW'(nb); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        to = 0;
        while (n_done == 0 && to < 20000) begin
            @(negedge clk);
            to++;
            start = poke && (to == 100);
            addr  = (poke && to == 100) ? ~a : a;
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("done_pulses", n_done, 1);
        check("done_busy_overlap", n_overlap, 0);
        check("nack", nack, !present);
        check("busy_cycles", busy_cycles, (11 + 9 * nx) * 4 * CD);
        check("start_cond", n_start, 1);
        check("stop_cond", n_stop, 1);
        check("bus_byte_count", bus_bytes.size(), 1 + nx);
        if (bus_bytes.size() > 0) check("addr_byte", bus_bytes[0], {a, r});
        for (int i = 0; i < nx && i + 1 < bus_bytes.size(); i++)
            check("data_byte", bus_bytes[i+1], r ? rd_src[i] : wr_src[i]);
        check("ack_slot_count", bus_acks.size(), 1 + nx);
        if (bus_acks.size() > 0) check("addr_ack", bus_acks[0], !present);
        for (int i = 0; i < nx && i + 1 < bus_acks.size(); i++)
            check("data_ack", bus_acks[i+1], r && (i == nx - 1));
        check("wr_ready_count", n_wr_ready, r ? 0 : nx);
        check("rd_valid_count", rd_seen.size(), r ? nx : 0);
        for (int i = 0; i < rd_seen.size() && i < rd_src.size(); i++)
            check("rd_data", rd_seen[i], rd_src[i]);
        wr_src.delete();
        rd_src.delete();
    endtask

    initial begin
        int to;
        #1;
        check("rst_scl", scl, 1);
        check("rst_sda_dir", sda_dir, 0);
        check("rst_sda_out", sda_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_nack", nack, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rd_data", rd_data, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed write of 0x30,0x01 to 0x58
        wr_src = '{8'h30, 8'h01};
        run_txn(7'h58, 1'b0, 2, 1'b1, 1'b0);
        // Directed read of 0xA5,0x3C,0xFF
        rd_src = '{8'hA5, 8'h3C, 8'hFF};
        run_txn(7'h58, 1'b1, 3, 1'b1, 1'b0);
        // No slave present: address NACK
        run_txn(7'h58, 1'b0, 2, 1'b0, 1'b0);
        // Zero-length probe
        run_txn(7'h21, 1'b0, 0, 1'b1, 1'b0);

        // Reset in the middle of the second read byte
        clear_logs();
        rd_src = '{8'h5A, 8'h00, 8'h81};
        slave_en = 1'b1;
        @(negedge clk);
        addr = 7'h58; rw = 1'b1; num_bytes = CW'(3); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        to = 0;
        while (rd_seen.size() < 1 && to < 5000) begin
            @(negedge clk);
            to++;
        end
        check("reset_wait_first_byte", rd_seen.size(), 1);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_scl", scl, 1);
        check("midreset_sda_dir", sda_dir, 0);
        check("midreset_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd_src.delete();
        repeat (2) @(negedge clk);
        run_txn(7'h58, 1'b1, 2, 1'b1, 1'b0);

        // Oversized count with a start pulse while busy
        run_txn(7'h3C, 1'b0, 31, 1'b1, 1'b1);

        // Randomized transactions
        for (int k = 0; k < 6; k++)
            run_txn(7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), $urandom_range(0, 4),
                    1'($urandom_range(0, 3) != 0), 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
